// File: rtl/apb_reg_pkg.sv
// Shared types, constants and address decode for the APB register slave.
package apb_reg_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      ACC  = 1'b1
   } apb_state_e;

   localparam int unsigned IDX_ID  = 0;
   localparam int unsigned IDX_STS = 1;
   localparam int unsigned WAIT_W  = 4;

   // An access errors on a misaligned address, an index past the map,
   // or a write aimed at one of the read-only words (ID, STATUS).
   function automatic logic decode_err(input logic [31:0] addr,
                                       input logic        write,
                                       input int unsigned num_regs);
      logic [31:0] word;
      word = {2'b00, addr[31:2]};
      return (addr[1:0] != 2'b00) || (word >= num_regs) ||
             (write && (word <= IDX_STS));
   endfunction

endpackage

// File: rtl/apb_slv_fsm.sv
// APB completer handshake: setup/access tracking, wait-state counter and
// abort detection. Address/direction/data are held from the setup edge.
module apb_slv_fsm
   import apb_reg_pkg::*;
#(
   parameter int WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        psel,
   input  logic        penable,
   input  logic [31:0] paddr,
   input  logic        pwrite,
   input  logic [31:0] pwdata,
   output logic        pready,
   output logic        acc_done,
   output logic        acc_abort,
   output logic [31:0] lat_addr,
   output logic        lat_write,
   output logic [31:0] lat_wdata
);

   // state | meaning
   // IDLE  | no transfer open; waiting for a setup phase (psel=1, penable=0)
   // ACC   | access phase; counting wait states, completes when cnt reaches 0

   apb_state_e        state_q, state_d;
   logic [WAIT_W-1:0] cnt_q, cnt_d;
   logic              load;

   // pready comes only from flops so the requester sees no input-to-output path
   assign pready = (state_q == ACC) && (cnt_q == '0);

   // State, wait counter and transfer latch
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         lat_addr  <= '0;
         lat_write <= 1'b0;
         lat_wdata <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (load) begin
            lat_addr  <= paddr;
            lat_write <= pwrite;
            lat_wdata <= pwdata;
         end
      end
   end

   // Next-state, counter and completion/abort decode
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      load      = 1'b0;
      acc_done  = 1'b0;
      acc_abort = 1'b0;
      case (state_q)
         IDLE: begin
            if (psel && !penable) begin
               state_d = ACC;
               cnt_d   = WAIT_W'(WAIT_CYCLES);
               load    = 1'b1;
            end
         end
         ACC: begin
            if (!(psel && penable)) begin
               acc_abort = 1'b1;
               state_d   = IDLE;
               cnt_d     = '0;
            end else if (cnt_q == '0) begin
               acc_done = 1'b1;
               state_d  = IDLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: rtl/apb_reg_slv.sv
// APB register slave: ID word, live status word and a bank of RW registers
// with per-register write strobes for the host block.
module apb_reg_slv
   import apb_reg_pkg::*;
#(
   parameter int          NUM_REGS    = 8,
   parameter int          WAIT_CYCLES = 1,
   parameter logic [31:0] ID_VALUE    = 32'h0A9B_0001
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   psel,
   input  logic                   penable,
   input  logic [31:0]            paddr,
   input  logic                   pwrite,
   input  logic [31:0]            pwdata,
   output logic                   pready,
   output logic [31:0]            prdata,
   output logic                   pslverr,
   input  logic [31:0]            sts_i,
   output logic [NUM_REGS*32-1:0] reg_q,
   output logic [NUM_REGS-1:0]    wr_pulse
);

   localparam int IDX_W = $clog2(NUM_REGS);

   logic             acc_done, acc_abort, lat_write, lat_err, commit;
   logic [31:0]      lat_addr, lat_wdata;
   logic [IDX_W-1:0] lat_idx;
   logic [31:0]      rw_q [2:NUM_REGS-1];

   apb_slv_fsm #(.WAIT_CYCLES(WAIT_CYCLES)) u_fsm (
      .clk       (clk),
      .rst       (rst),
      .psel      (psel),
      .penable   (penable),
      .paddr     (paddr),
      .pwrite    (pwrite),
      .pwdata    (pwdata),
      .pready    (pready),
      .acc_done  (acc_done),
      .acc_abort (acc_abort),
      .lat_addr  (lat_addr),
      .lat_write (lat_write),
      .lat_wdata (lat_wdata)
   );

   assign lat_err = decode_err(lat_addr, lat_write, NUM_REGS);
   assign lat_idx = lat_addr[IDX_W+1:2];
   assign commit  = acc_done && !acc_abort && lat_write && !lat_err;
   assign pslverr = pready && lat_err;

   // Register bank update and one-cycle write strobe after each committed write
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 2; i < NUM_REGS; i++) rw_q[i] <= '0;
         wr_pulse <= '0;
      end else begin
         wr_pulse <= '0;
         for (int i = 2; i < NUM_REGS; i++) begin
            if (commit && (lat_idx == IDX_W'(i))) begin
               rw_q[i]     <= lat_wdata;
               wr_pulse[i] <= 1'b1;
            end
         end
      end
   end

   // Read data mux; driven to zero outside the pready cycle and on errors
   always_comb begin
      prdata = '0;
      if (pready && !lat_write && !lat_err) begin
         if (lat_idx == IDX_W'(IDX_ID)) begin
            prdata = ID_VALUE;
         end else if (lat_idx == IDX_W'(IDX_STS)) begin
            prdata = sts_i;
         end else begin
            for (int i = 2; i < NUM_REGS; i++) begin
               if (lat_idx == IDX_W'(i)) prdata = rw_q[i];
            end
         end
      end
   end

   assign reg_q[31:0]  = ID_VALUE;
   assign reg_q[63:32] = sts_i;
   for (genvar g = 2; g < NUM_REGS; g++) begin : g_slot
      assign reg_q[g*32 +: 32] = rw_q[g];
   end

endmodule

// File: tb/tb_apb_reg_slv.sv
// Bench for apb_reg_slv: three instances (1, 0 and 3 wait states) driven
// by directed and random APB transfers, checked against a register-map model.
module tb_apb_reg_slv;

   localparam int          NDUT = 3;
   localparam int          NREG = 8;
   localparam logic [31:0] ID   = 32'h0A9B_0001;
   localparam int          WAITS [NDUT] = '{1, 0, 3};

   logic        clk = 1'b0;
   logic        rst     [NDUT];
   logic        psel    [NDUT];
   logic        penable [NDUT];
   logic        pwrite  [NDUT];
   logic [31:0] paddr   [NDUT];
   logic [31:0] pwdata  [NDUT];
   logic [31:0] sts_i   [NDUT];
   logic        pready  [NDUT];
   logic        pslverr [NDUT];
   logic [31:0] prdata  [NDUT];
   logic [NREG*32-1:0] reg_q    [NDUT];
   logic [NREG-1:0]    wr_pulse [NDUT];

   logic [31:0] mdl [NDUT][NREG];
   int          exp_pulses [NDUT];
   int          seen_pulses [NDUT];
   int          n_chk = 0;
   int          n_fail = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      apb_reg_slv #(.NUM_REGS(NREG), .WAIT_CYCLES(WAITS[g]), .ID_VALUE(ID)) u_dut (
         .clk      (clk),
         .rst      (rst[g]),
         .psel     (psel[g]),
         .penable  (penable[g]),
         .paddr    (paddr[g]),
         .pwrite   (pwrite[g]),
         .pwdata   (pwdata[g]),
         .pready   (pready[g]),
         .prdata   (prdata[g]),
         .pslverr  (pslverr[g]),
         .sts_i    (sts_i[g]),
         .reg_q    (reg_q[g]),
         .wr_pulse (wr_pulse[g])
      );
   end

   // Count every strobe bit seen; compared against committed writes at the end
   always @(negedge clk) begin
      for (int k = 0; k < NDUT; k++) seen_pulses[k] += $countones(wr_pulse[k]);
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
      end
   endtask

   function automatic bit exp_err(input int unsigned a, input bit wr);
      return (a % 4 != 0) || (a / 4 >= NREG) || (wr && (a / 4 < 2));
   endfunction

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Full APB transfer starting at a drive point (#1 after an edge); returns
   // at the drive point after the completion edge with psel/penable low.
   task automatic xfer(input int k, input int unsigned a, input bit wr, input logic [31:0] wd);
      int          n;
      bit          e;
      logic [31:0] er;
      psel[k] = 1'b1; penable[k] = 1'b0; paddr[k] = a; pwrite[k] = wr; pwdata[k] = wd;
      @(posedge clk); #1;
      penable[k] = 1'b1;
      n = 2;
      @(negedge clk);
      while (!pready[k] && n < 40) begin
         check("quiet_wait", {prdata[k], 31'b0, pslverr[k]}, 64'h0);
         @(posedge clk); #1;
         @(negedge clk);
         n++;
      end
      check("latency", 64'(n), 64'(WAITS[k] + 2));
      e = exp_err(a, wr);
      check("pslverr", 64'(pslverr[k]), 64'(e));
      if (!wr) begin
         if (e)              er = 32'h0;
         else if (a / 4 == 0) er = ID;
         else if (a / 4 == 1) er = sts_i[k];
         else                er = mdl[k][a / 4];
         check("prdata", 64'(prdata[k]), 64'(er));
      end else if (!e) begin
         mdl[k][a / 4] = wd;
         exp_pulses[k]++;
      end
      @(posedge clk); #1;
      psel[k] = 1'b0; penable[k] = 1'b0;
   endtask

   task automatic chk_regs(input int k);
      logic [31:0] ev;
      for (int i = 0; i < NREG; i++) begin
         ev = (i == 0) ? ID : (i == 1) ? sts_i[k] : mdl[k][i];
         check("reg_q", 64'(reg_q[k][i*32 +: 32]), 64'(ev));
      end
   endtask

   task automatic clear_model(input int k);
      for (int i = 0; i < NREG; i++) mdl[k][i] = 32'h0;
   endtask

   initial begin
      int unsigned a;
      for (int k = 0; k < NDUT; k++) begin
         rst[k] = 1'b1; psel[k] = 1'b0; penable[k] = 1'b0; pwrite[k] = 1'b0;
         paddr[k] = '0; pwdata[k] = '0; sts_i[k] = '0;
         exp_pulses[k] = 0; seen_pulses[k] = 0;
         clear_model(k);
      end
      idle(2);
      for (int k = 0; k < NDUT; k++) rst[k] = 1'b0;
      for (int k = 0; k < NDUT; k++) begin
         check("rst_pready", 64'(pready[k]), 64'h0);
         check("rst_prdata", 64'(prdata[k]), 64'h0);
         check("rst_pslverr", 64'(pslverr[k]), 64'h0);
         check("rst_wr_pulse", 64'(wr_pulse[k]), 64'h0);
         chk_regs(k);
      end

      // One wait state: ID read, write/readback with strobe, error cases, status
      xfer(0, 32'h0, 1'b0, 32'h0);
      xfer(0, 32'h8, 1'b1, 32'hDEAD_BEEF);
      check("wr_pulse_on", 64'(wr_pulse[0]), 64'h04);
      check("reg2_new", 64'(reg_q[0][64 +: 32]), 64'hDEAD_BEEF);
      idle(1);
      check("wr_pulse_off", 64'(wr_pulse[0]), 64'h00);
      xfer(0, 32'h8, 1'b0, 32'h0);
      xfer(0, 32'h4, 1'b1, 32'h5555_AAAA);
      xfer(0, 32'h20, 1'b0, 32'h0);
      xfer(0, 32'hA, 1'b0, 32'h0);
      sts_i[0] = 32'h1234_5678;
      xfer(0, 32'h4, 1'b0, 32'h0);
      chk_regs(0);

      // Zero wait states: back-to-back writes, then immediate readbacks
      xfer(1, 32'h8, 1'b1, 32'h1111_2222);
      xfer(1, 32'hC, 1'b1, 32'h3333_4444);
      xfer(1, 32'h8, 1'b0, 32'h0);
      xfer(1, 32'hC, 1'b0, 32'h0);
      chk_regs(1);

      // Three wait states: requester drops penable after one wait cycle
      psel[2] = 1'b1; penable[2] = 1'b0; paddr[2] = 32'h10; pwrite[2] = 1'b1;
      pwdata[2] = 32'hBAD0_0001;
      idle(1);
      penable[2] = 1'b1;
      @(negedge clk); check("abort_pready0", 64'(pready[2]), 64'h0);
      idle(1);
      psel[2] = 1'b0; penable[2] = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); check("abort_pready", 64'(pready[2]), 64'h0);
         idle(1);
      end
      chk_regs(2);
      xfer(2, 32'h14, 1'b1, 32'hCAFE_0005);
      xfer(2, 32'h14, 1'b0, 32'h0);

      // Reset during the wait phase of a write to 0x10
      psel[2] = 1'b1; penable[2] = 1'b0; paddr[2] = 32'h10; pwrite[2] = 1'b1;
      pwdata[2] = 32'hFEED_0004;
      idle(1);
      penable[2] = 1'b1;
      idle(1);
      rst[2] = 1'b1;
      idle(1);
      rst[2] = 1'b0;
      clear_model(2);
      check("mid_rst_prdata", 64'(prdata[2]), 64'h0);
      check("mid_rst_pslverr", 64'(pslverr[2]), 64'h0);
      check("mid_rst_wr_pulse", 64'(wr_pulse[2]), 64'h0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); check("mid_rst_pready", 64'(pready[2]), 64'h0);
         idle(1);
      end
      psel[2] = 1'b0; penable[2] = 1'b0;
      chk_regs(2);

      // Random traffic on every instance
      for (int k = 0; k < NDUT; k++) begin
         for (int t = 0; t < 40; t++) begin
            a = $urandom_range(0, 9) * 4;
            if ($urandom_range(0, 7) == 0) a += $urandom_range(1, 3);
            sts_i[k] = $urandom;
            xfer(k, a, 1'($urandom_range(0, 1)), $urandom);
            if ($urandom_range(0, 1) == 1) idle(1);
            if (t % 8 == 7) chk_regs(k);
         end
         chk_regs(k);
      end

      idle(2);
      for (int k = 0; k < NDUT; k++) check("strobe_count", 64'(seen_pulses[k]), 64'(exp_pulses[k]));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/apb_reg_slv.md
# apb_reg_slv

APB completer (slave) with a small memory-mapped register bank: accepts setup/access transfers from an APB requester, inserts a parameterised number of wait states, then completes with read data or error. Sits at the SLV end of `APB_IF` and serves as the configuration/status port of a block, e.g. a DMA or AXI traffic engine. Exposes RW register contents and per-register write strobes to the host block, and takes one read-only status word from it.

## Interface
- `NUM_REGS`, 8: word registers in the map, minimum 3; index 0 = ID (RO), 1 = STATUS (RO), 2..NUM_REGS-1 = RW.
- `WAIT_CYCLES`, 1: wait states inserted in every access phase, 0..15.
- `ID_VALUE`, 32'h0A9B_0001: constant returned by register 0.

- `clk`  in  1  clock, all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `psel`  in  1  APB select.
- `penable`  in  1  APB enable; 0 = setup phase, 1 = access phase.
- `paddr`  in  32  byte address; word index = paddr[31:2].
- `pwrite`  in  1  1 = write, 0 = read.
- `pwdata`  in  32  write data.
- `pready`  out  1  transfer completes this cycle.
- `prdata`  out  32  read data, valid only while pready=1.
- `pslverr`  out  1  error response, valid only while pready=1.
- `sts_i`  in  32  live status word, read at index 1.
- `reg_q`  out  NUM_REGS*32  flattened register values; slot i = reg i; slots 0/1 mirror ID/STATUS.
- `wr_pulse`  out  NUM_REGS  one-cycle strobe for the register written.

## Operation
- FSM states: IDLE, ACC.
- IDLE -> ACC on an edge sampling psel=1, penable=0. The edge latches paddr/pwrite/pwdata and loads the wait counter `cnt` with WAIT_CYCLES.
- IDLE with psel=1, penable=1 (no setup phase seen): ignored; stays IDLE, pready=0.
- ACC, psel=1, penable=1, cnt!=0: cnt decrements each edge.
- ACC, psel=1, penable=1, cnt==0: pready=1; the edge completes the transfer and returns the FSM to IDLE.
- ACC with psel=0 or penable=0 at an edge: abort. Go to IDLE, no write, no strobe.
- Decode of the latched address:
  - Error if paddr[1:0]!=0, or word index >= NUM_REGS, or write to index 0/1.
  - On error: pslverr=1 during the pready cycle; no register changes.
- Write OK: reg[idx] <= pwdata at the completion edge; wr_pulse[idx]=1 for the following cycle only.
- Read: prdata = ID_VALUE, the sts_i value sampled in the pready cycle, or reg[idx].
- Erroring reads return prdata=0.
- When pready=0: prdata=0 and pslverr=0.
- Reset: FSM=IDLE, cnt=0, pready=0, prdata=0, pslverr=0, wr_pulse=0, all RW regs=0.
- Reset asserted mid-transfer: the transfer is dropped and the write is not committed; pready stays 0 until a new setup phase.

## Timing
- Cycle S = setup cycle; its edge moves FSM to ACC.
- pready rises in cycle S+1+WAIT_CYCLES; total transfer = WAIT_CYCLES+2 cycles. WAIT_CYCLES=0 gives zero-wait, 2-cycle transfers.
- pready is decoded from flops only (state, cnt), with no combinational path from APB inputs.
- Back-to-back transfers: a new setup in the cycle right after completion is accepted with no idle bubble.
- Write data is visible on reg_q one cycle after the completion edge, in the same cycle as wr_pulse.
- A read immediately after a write returns the new value.

## Structure
- Package `apb_reg_pkg`:
  - state enum (IDLE, ACC);
  - constants IDX_ID=0, IDX_STS=1, WAIT_W=4;
  - function `decode_err(addr, write, num_regs)`.
- Sub-module `apb_slv_fsm`: APB handshake, wait counter, abort detection.
  - Outputs: `acc_done`, `acc_abort`, latched addr/write/wdata.
- Top level `apb_reg_slv` holds the register bank, decode, read mux and strobes.

## Test plan
- Reset, then read 0x0 with WAIT_CYCLES=1 -> pready in the 3rd cycle, prdata=32'h0A9B_0001, pslverr=0.
- Write 0x8 = 32'hDEAD_BEEF, then read 0x8 -> reg_q slot 2 = DEADBEEF; wr_pulse=8'b0000_0100 for exactly 1 cycle; readback DEADBEEF.
- Error cases, each -> pslverr=1 with prdata=0:
  - write 0x4 (RO status): reg_q unchanged, no wr_pulse;
  - read 0x20 (index 8 >= NUM_REGS);
  - read 0xA (misaligned).
- sts_i=32'h1234_5678, read 0x4 -> prdata=12345678. WAIT_CYCLES=0 build: every transfer 2 cycles; back-to-back writes to 0x8, 0xC both commit.
- Master drops penable after 1 wait cycle (WAIT_CYCLES=3) -> no pready, no write; next normal transfer completes correctly.
- rst pulsed during the wait phase of a write to 0x10 -> reg 4 stays 0, pready stays 0, all outputs at reset values.
